// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, taken-branch flush, memory freeze.
// Drives stage enables and bubble/flush strobes; keeps stall/flush counters.
module id_ex_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rn_id,
  input  logic [4:0]       Rm_id,
  input  logic             rn_used_id,
  input  logic             rm_used_id,
  input  logic [4:0]       Rd_ex,
  input  logic             MemtoReg_ex,
  input  logic             RegWrite_ex,
  input  logic             br_taken_ex,
  input  logic             mem_access_mem,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              tmo_q;

  logic              hazard, miss;
  logic [4:0]        en_c;
  logic              flush_c, bubble_c;
  logic              stall_inc, flush_inc;

  assign hazard = MemtoReg_ex & RegWrite_ex & (Rd_ex != 5'd31) &
                  ((rn_used_id & (Rn_id == Rd_ex)) |
                   (rm_used_id & (Rm_id == Rd_ex)));
  assign miss   = mem_access_mem & ~mem_ready;

  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    en_c      = 5'b11111;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      RUN, LU_STALL: begin
        state_d = RUN;
        if (miss) begin
          en_c      = 5'b00000;
          state_d   = MEM_WAIT;
          wc_d      = WC_W'(1);
          stall_inc = 1'b1;
        end else if (br_taken_ex) begin
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          flush_inc = 1'b1;
        end else if (hazard && state_q == RUN) begin
          en_c      = 5'b00111;
          bubble_c  = 1'b1;
          stall_inc = 1'b1;
          state_d   = LU_STALL;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          en_c      = 5'b00000;
          stall_inc = 1'b1;
          if (wc_q != WC_MAX) wc_d = wc_q + WC_W'(1);
        end else begin
          state_d = RUN;
          wc_d    = '0;
        end
      end
      default: begin
        state_d = RUN;
        wc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wc_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      if (stall_inc && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      if (wc_d == WC_MAX) tmo_q <= 1'b1;
    end
  end

  // Reset forces the quiescent strobe pattern without waiting for an edge.
  assign pc_en        = reset & en_c[4];
  assign if_id_en     = reset & en_c[3];
  assign id_ex_en     = reset & en_c[2];
  assign ex_mem_en    = reset & en_c[1];
  assign mem_wb_en    = reset & en_c[0];
  assign if_id_flush  = ~reset | flush_c;
  assign id_ex_bubble = ~reset | bubble_c;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign mem_timeout  = tmo_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Scoreboard bench for id_ex_hazard_ctrl: driver queues expectations,
// monitor pops and compares on each falling edge.
module tb_id_ex_hazard_ctrl;

  localparam int CW = 3;
  localparam logic [4:0] EN1 = 5'b11111;
  localparam logic [4:0] LU  = 5'b00111;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    Rn_id = '0, Rm_id = '0, Rd_ex = '0;
  logic          rn_used_id = 0, rm_used_id = 0;
  logic          MemtoReg_ex = 0, RegWrite_ex = 0, br_taken_ex = 0;
  logic          mem_access_mem = 0, mem_ready = 1;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en;
  logic          id_ex_bubble, ex_mem_en, mem_wb_en, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  id_ex_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rn_id(Rn_id), .Rm_id(Rm_id),
    .rn_used_id(rn_used_id), .rm_used_id(rm_used_id),
    .Rd_ex(Rd_ex), .MemtoReg_ex(MemtoReg_ex),
    .RegWrite_ex(RegWrite_ex), .br_taken_ex(br_taken_ex),
    .mem_access_mem(mem_access_mem), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .mem_timeout(mem_timeout)
  );

  typedef struct {
    int            id;
    logic [4:0]    en;
    logic          fl;
    logic          bb;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic          to;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   step_id = 0;

  task automatic chk(input string name, input int id,
                     input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL step %0d %s: got %0h expected %0h",
               id, name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("enables", e.id,
            {3'b0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
            {3'b0, e.en});
        chk("if_id_flush", e.id, {7'b0, if_id_flush}, {7'b0, e.fl});
        chk("id_ex_bubble", e.id, {7'b0, id_ex_bubble}, {7'b0, e.bb});
        chk("stall_cycles", e.id, 8'(stall_cycles), 8'(e.sc));
        chk("flush_count", e.id, 8'(flush_count), 8'(e.fc));
        chk("mem_timeout", e.id, {7'b0, mem_timeout}, {7'b0, e.to});
      end
    end
  end

  // mode: 0 = reset held, 1 = running, 2 = reset dropped mid-cycle
  task automatic cyc(input int mode, input logic ld,
                     input logic [4:0] rd, input logic [4:0] rn,
                     input logic rnu, input logic [4:0] rm,
                     input logic rmu, input logic br,
                     input logic acc, input logic rdy,
                     input logic [4:0] en, input logic fl,
                     input logic bb, input int sc, input int fc,
                     input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = (mode != 0);
    MemtoReg_ex    = ld;
    RegWrite_ex    = ld;
    Rd_ex          = rd;
    Rn_id          = rn;
    rn_used_id     = rnu;
    Rm_id          = rm;
    rm_used_id     = rmu;
    br_taken_ex    = br;
    mem_access_mem = acc;
    mem_ready      = rdy;
    e.id = step_id;
    e.en = en;
    e.fl = fl;
    e.bb = bb;
    e.sc = CW'(sc);
    e.fc = CW'(fc);
    e.to = to;
    q.push_back(e);
    step_id++;
    if (mode == 2) begin
      #2;
      reset = 1'b0;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    // reset held, then release into RUN
    cyc(0, 0,0,0,0,0,0, 0,0,1, 5'b0,1,1, 0,0,0);
    cyc(0, 0,0,0,0,0,0, 0,0,1, 5'b0,1,1, 0,0,0);
    cyc(1, 0,0,0,0,0,0, 0,0,1, EN1,0,0, 0,0,0);
    // load-use on Rn: exactly one bubble
    cyc(1, 1,5,5,1,0,0, 0,0,1, LU, 0,1, 0,0,0);
    cyc(1, 1,5,5,1,0,0, 0,0,1, EN1,0,0, 1,0,0);
    // X31 never hazards
    cyc(1, 1,31,31,1,31,1, 0,0,1, EN1,0,0, 1,0,0);
    cyc(1, 1,31,31,1,31,1, 0,0,1, EN1,0,0, 1,0,0);
    // load-use on Rm
    cyc(1, 1,7,0,0,7,1, 0,0,1, LU, 0,1, 1,0,0);
    cyc(1, 0,0,0,0,0,0, 0,0,1, EN1,0,0, 2,0,0);
    // matching register but not read
    cyc(1, 1,9,9,0,3,1, 0,0,1, EN1,0,0, 2,0,0);
    // branch beats hazard
    cyc(1, 1,5,5,1,0,0, 1,0,1, EN1,1,1, 2,0,0);
    cyc(1, 0,0,0,0,0,0, 0,0,1, EN1,0,0, 2,1,0);
    // miss with branch pending: freeze 3, release, then flush
    cyc(1, 0,0,0,0,0,0, 1,1,0, 5'b0,0,0, 2,1,0);
    cyc(1, 0,0,0,0,0,0, 1,1,0, 5'b0,0,0, 3,1,0);
    cyc(1, 0,0,0,0,0,0, 1,1,0, 5'b0,0,0, 4,1,0);
    cyc(1, 0,0,0,0,0,0, 1,1,1, EN1,0,0, 5,1,0);
    cyc(1, 0,0,0,0,0,0, 1,0,1, EN1,1,1, 5,1,0);
    cyc(1, 0,0,0,0,0,0, 0,0,1, EN1,0,0, 5,2,0);
    // clean slate for timeout
    cyc(0, 0,0,0,0,0,0, 0,0,1, 5'b0,1,1, 0,0,0);
    cyc(1, 0,0,0,0,0,0, 0,0,1, EN1,0,0, 0,0,0);
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 0,0,0);
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 1,0,0);
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 2,0,0);
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 3,0,0);
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 4,0,1);
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 5,0,1);
    cyc(1, 0,0,0,0,0,0, 0,1,1, EN1,0,0, 6,0,1);
    cyc(1, 0,0,0,0,0,0, 0,0,1, EN1,0,0, 6,0,1);
    // stall counter saturates at 7
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 6,0,1);
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 7,0,1);
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 7,0,1);
    cyc(1, 0,0,0,0,0,0, 0,1,1, EN1,0,0, 7,0,1);
    // flush counter saturates at 7
    for (int i = 0; i < 8; i++)
      cyc(1, 0,0,0,0,0,0, 1,0,1, EN1,1,1, 7,i,1);
    cyc(1, 0,0,0,0,0,0, 0,0,1, EN1,0,0, 7,7,1);
    // async reset mid MEM_WAIT
    cyc(1, 0,0,0,0,0,0, 0,1,0, 5'b0,0,0, 7,7,1);
    cyc(2, 0,0,0,0,0,0, 0,1,0, 5'b0,1,1, 0,0,0);
    cyc(1, 0,0,0,0,0,0, 0,0,1, EN1,0,0, 0,0,0);
    // async reset mid LU_STALL: hazard detected again after release
    cyc(1, 1,5,5,1,0,0, 0,0,1, LU, 0,1, 0,0,0);
    cyc(2, 1,5,5,1,0,0, 0,0,1, 5'b0,1,1, 0,0,0);
    cyc(1, 1,5,5,1,0,0, 0,0,1, LU, 0,1, 0,0,0);
    cyc(1, 0,0,0,0,0,0, 0,0,1, EN1,0,0, 1,0,0);
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
